pipe_control_unit: RTL

Pipelined, parametrised control unit for the 4-stage (D/E/M/W) core. Decodes the opcode in D, then carries the control word through E, M and W pipeline registers. Generates the jump flush, folds in the external load-use stall, and sequences a multi-cycle MUL through a small FSM that freezes D/E while the multiplier runs. It replaces the purely combinational decoder-plus-wrapper used so far.

---
 rtl/pipe_control_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: D-stage opcode decode feeding E/M/W control registers,
// with jump flush, load-use stall folding and an optional multi-cycle MUL
// sequencer that freezes D/E while the multiplier runs.
// Build option: define PIPE_CTRL_MUL_EN to include MUL decode, the MUL FSM and
// its counter. Without it opcode 9 is illegal, mulE is always 0 and o_stall
// simply follows i_stall.
//
// state    | meaning
// IDLE     | no MUL sequencing; a MUL sitting in E here is in its first cycle
// MUL_BUSY | MUL occupying E; count reaches 0 on the MUL's last cycle in E
module pipe_control_unit #(
    parameter int OP_W       = 4,
    parameter int ALU_W      = 2,
    parameter int MUL_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [OP_W-1:0]  i_opcode,
    input  logic             i_valid,
    input  logic             i_stall,
    output logic             jumpE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             immediateE,
    output logic             mulE,
    output logic             validE,
    output logic [ALU_W-1:0] alufuncE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             validM,
    output logic             RegWriteW,
    output logic             validW,
    output logic             o_flush,
    output logic             o_stall,
    output logic             o_illegal
);

    typedef struct packed {
        logic       valid;
        logic       jump;
        logic       reg_write;
        logic       mem_write;
        logic       immediate;
        logic       mul;
        logic [1:0] alufunc;
    } ctrl_t;

    ctrl_t dec;
    logic  dec_illegal;
    ctrl_t ctrl_e;
    logic  m_reg_write, m_mem_write, m_valid;
    logic  w_reg_write, w_valid;
    logic  illegal_q;
    logic  busy, last_mul, hold;

    if (OP_W < 4 || ALU_W < 2 || MUL_CYCLES < 2) begin : g_param_check
        $error("pipe_control_unit: need OP_W>=4, ALU_W>=2, MUL_CYCLES>=2");
    end

    // Decode the D-stage opcode; no valid instruction or an illegal one gives a bubble.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        if (i_valid) begin
            if ((i_opcode >> 4) != '0) begin
                dec_illegal = 1'b1;
            end else begin
                case (i_opcode[3:0])
                    4'd0: dec.valid = 1'b1;
                    4'd1: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alufunc = 2'b00; end
                    4'd2: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alufunc = 2'b01; end
                    4'd3: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alufunc = 2'b10; end
                    4'd4: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alufunc = 2'b11; end
                    4'd5: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.immediate = 1'b1; end
                    4'd6: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.immediate = 1'b1; end
                    4'd7: begin dec.valid = 1'b1; dec.mem_write = 1'b1; dec.immediate = 1'b1; end
                    4'd8: begin dec.valid = 1'b1; dec.jump = 1'b1; end
`ifdef PIPE_CTRL_MUL_EN
                    4'd9: begin dec.valid = 1'b1; dec.reg_write = 1'b1; dec.mul = 1'b1; end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Sequence the MUL: the first E cycle is spent in IDLE, the rest count down in MUL_BUSY.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_e.valid && ctrl_e.mul) begin
                        state <= MUL_BUSY;
                        count <= CNT_W'(MUL_CYCLES - 2);
                    end
                end
                MUL_BUSY: begin
                    if (count == '0) state <= IDLE;
                    else             count <= count - CNT_W'(1);
                end
            endcase
        end
    end

    assign busy     = (state == IDLE && ctrl_e.valid && ctrl_e.mul) || (state == MUL_BUSY);
    assign last_mul = (state == MUL_BUSY) && (count == '0);
`else
    assign busy     = 1'b0;
    assign last_mul = 1'b0;
`endif

    // On the MUL's last cycle E is free to take the next word, so only earlier cycles hold.
    assign hold    = busy && !last_mul;
    assign o_flush = ctrl_e.valid && ctrl_e.jump && !busy;
    assign o_stall = i_stall || hold;

    // Advance the control pipeline: E holds for MUL, else bubbles on flush/stall or takes D.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_e      <= '0;
            m_reg_write <= 1'b0;
            m_mem_write <= 1'b0;
            m_valid     <= 1'b0;
            w_reg_write <= 1'b0;
            w_valid     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            w_reg_write <= m_reg_write;
            w_valid     <= m_valid;
            if (hold) begin
                m_reg_write <= 1'b0;
                m_mem_write <= 1'b0;
                m_valid     <= 1'b0;
                illegal_q   <= 1'b0;
            end else begin
                m_reg_write <= ctrl_e.reg_write;
                m_mem_write <= ctrl_e.mem_write;
                m_valid     <= ctrl_e.valid;
                if (o_flush || i_stall) begin
                    ctrl_e    <= '0;
                    illegal_q <= 1'b0;
                end else begin
                    ctrl_e    <= dec;
                    illegal_q <= dec_illegal;
                end
            end
        end
    end

    assign jumpE      = ctrl_e.jump;
    assign RegWriteE  = ctrl_e.reg_write;
    assign MemWriteE  = ctrl_e.mem_write;
    assign immediateE = ctrl_e.immediate;
    assign mulE       = ctrl_e.mul;
    assign validE     = ctrl_e.valid;
    assign alufuncE   = ALU_W'(ctrl_e.alufunc);
    assign RegWriteM  = m_reg_write;
    assign MemWriteM  = m_mem_write;
    assign validM     = m_valid;
    assign RegWriteW  = w_reg_write;
    assign validW     = w_valid;
    assign o_illegal  = illegal_q;

endmodule
